// File: rtl/ctrl_decode_stage_pkg.sv
// Shared types for the decode control stage: opcode enum (RV32I + M extension), control-field
// enums, the packed control bundle and its all-disabled NOP value.
package ctrl_decode_stage_pkg;

   typedef enum logic [5:0] {
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      LB, LH, LW, LBU, LHU, SB, SH, SW,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      JAL, JALR, LUI, AUIPC, ECALL, EBREAK,
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
      ILLEGAL
   } opcode_out_t;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_op_t;

   typedef enum logic [2:0] {
      COMP_EQ, COMP_NE, COMP_LT, COMP_GE, COMP_LTU, COMP_GEU
   } comp_op_t;

   typedef enum logic [1:0] {WRSRC_ALURES, WRSRC_MEMREAD, WRSRC_PC4} reg_wr_src_t;
   typedef enum logic [1:0] {SRC1_REG1, SRC1_PC, SRC1_ZERO} alu_src1_t;
   typedef enum logic {SRC2_REG2, SRC2_IMM} alu_src2_t;

   typedef enum logic [2:0] {
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
   } mem_op_t;

   typedef struct packed {
      logic        reg_do_write;
      logic        mem_do_write;
      logic        mem_do_read;
      logic        do_branch;
      logic        do_jump;
      comp_op_t    comp_op;
      reg_wr_src_t wr_src;
      alu_src1_t   alu_src1;
      alu_src2_t   alu_src2;
      alu_op_t     alu_op;
      mem_op_t     mem_op;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_NOP = '{
      reg_do_write: 1'b0,
      mem_do_write: 1'b0,
      mem_do_read:  1'b0,
      do_branch:    1'b0,
      do_jump:      1'b0,
      comp_op:      COMP_EQ,
      wr_src:       WRSRC_ALURES,
      alu_src1:     SRC1_REG1,
      alu_src2:     SRC2_REG2,
      alu_op:       ALU_ADD,
      mem_op:       MEM_LB
   };

   // Wide enough for DIV_CYCLES-1 up to 31.
   localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Handshake bundle between the ID decoder (master) and the decode control stage (slave).
//   opcode_in/in_valid/in_ready : upstream valid/ready
//   flush                       : redirect kill
//   ctrl_out/out_valid/out_ready: downstream valid/ready towards EX
//   mc_busy/illegal_instr/sys_trap: registered status of the held instruction
interface ctrl_decode_stage_if;
   import ctrl_decode_stage_pkg::*;

   opcode_out_t  opcode_in;
   logic         in_valid;
   logic         in_ready;
   logic         flush;
   logic         out_ready;
   logic         out_valid;
   ctrl_bundle_t ctrl_out;
   logic         mc_busy;
   logic         illegal_instr;
   logic         sys_trap;

   modport master (
      output opcode_in, in_valid, flush, out_ready,
      input  in_ready, out_valid, ctrl_out, mc_busy, illegal_instr, sys_trap
   );

   modport slave (
      input  opcode_in, in_valid, flush, out_ready,
      output in_ready, out_valid, ctrl_out, mc_busy, illegal_instr, sys_trap
   );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode -> control bundle decode.
//   opcode  : decoded opcode from ID
//   ctrl    : control bundle (CTRL_NOP for illegal and system instructions)
//   is_mul  : legal MUL-group op (multi-cycle)
//   is_div  : legal DIV/REM-group op (multi-cycle)
//   illegal : undefined opcode, or M op with ENABLE_M=0
//   sys     : ECALL / EBREAK
module ctrl_decode_comb
   import ctrl_decode_stage_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  opcode_out_t  opcode,
   output ctrl_bundle_t ctrl,
   output logic         is_mul,
   output logic         is_div,
   output logic         illegal,
   output logic         sys
);

   alu_op_t  alu_sel;
   mem_op_t  mem_sel;
   comp_op_t comp_sel;

   // Per-opcode sub-field selection; only consumed by the groups that use it.
   always_comb begin
      alu_sel  = ALU_ADD;
      mem_sel  = MEM_LB;
      comp_sel = COMP_EQ;
      case (opcode)
         SUB:          alu_sel = ALU_SUB;
         SLL, SLLI:    alu_sel = ALU_SLL;
         SLT, SLTI:    alu_sel = ALU_SLT;
         SLTU, SLTIU:  alu_sel = ALU_SLTU;
         XOR, XORI:    alu_sel = ALU_XOR;
         SRL, SRLI:    alu_sel = ALU_SRL;
         SRA, SRAI:    alu_sel = ALU_SRA;
         OR, ORI:      alu_sel = ALU_OR;
         AND, ANDI:    alu_sel = ALU_AND;
         MUL:          alu_sel = ALU_MUL;
         MULH:         alu_sel = ALU_MULH;
         MULHSU:       alu_sel = ALU_MULHSU;
         MULHU:        alu_sel = ALU_MULHU;
         DIV:          alu_sel = ALU_DIV;
         DIVU:         alu_sel = ALU_DIVU;
         REM:          alu_sel = ALU_REM;
         REMU:         alu_sel = ALU_REMU;
         LH:           mem_sel = MEM_LH;
         LW:           mem_sel = MEM_LW;
         LBU:          mem_sel = MEM_LBU;
         LHU:          mem_sel = MEM_LHU;
         SB:           mem_sel = MEM_SB;
         SH:           mem_sel = MEM_SH;
         SW:           mem_sel = MEM_SW;
         BNE:          comp_sel = COMP_NE;
         BLT:          comp_sel = COMP_LT;
         BGE:          comp_sel = COMP_GE;
         BLTU:         comp_sel = COMP_LTU;
         BGEU:         comp_sel = COMP_GEU;
         default: ;
      endcase
   end

   always_comb begin
      ctrl    = CTRL_NOP;
      is_mul  = 1'b0;
      is_div  = 1'b0;
      illegal = 1'b0;
      sys     = 1'b0;
      case (opcode)
         ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: begin
            ctrl.reg_do_write = 1'b1;
            ctrl.alu_op       = alu_sel;
         end
         ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI: begin
            ctrl.reg_do_write = 1'b1;
            ctrl.alu_src2     = SRC2_IMM;
            ctrl.alu_op       = alu_sel;
         end
         LB, LH, LW, LBU, LHU: begin
            ctrl.reg_do_write = 1'b1;
            ctrl.mem_do_read  = 1'b1;
            ctrl.alu_src2     = SRC2_IMM;
            ctrl.wr_src       = WRSRC_MEMREAD;
            ctrl.mem_op       = mem_sel;
         end
         SB, SH, SW: begin
            ctrl.mem_do_write = 1'b1;
            ctrl.alu_src2     = SRC2_IMM;
            ctrl.mem_op       = mem_sel;
         end
         BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
            // ALU computes the target (PC + imm); comparator decides taken.
            ctrl.do_branch = 1'b1;
            ctrl.alu_src1  = SRC1_PC;
            ctrl.alu_src2  = SRC2_IMM;
            ctrl.comp_op   = comp_sel;
         end
         JAL, JALR: begin
            ctrl.do_jump      = 1'b1;
            ctrl.reg_do_write = 1'b1;
            ctrl.wr_src       = WRSRC_PC4;
            ctrl.alu_src1     = (opcode == JAL) ? SRC1_PC : SRC1_REG1;
            ctrl.alu_src2     = SRC2_IMM;
         end
         LUI, AUIPC: begin
            ctrl.reg_do_write = 1'b1;
            ctrl.alu_src1     = (opcode == LUI) ? SRC1_ZERO : SRC1_PC;
            ctrl.alu_src2     = SRC2_IMM;
         end
         ECALL, EBREAK: sys = 1'b1;
         MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: begin
            if (ENABLE_M) begin
               ctrl.reg_do_write = 1'b1;
               ctrl.alu_op       = alu_sel;
               is_mul            = opcode inside {MUL, MULH, MULHSU, MULHU};
               is_div            = !is_mul;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode control stage between the ID decoder and the ID/EX boundary.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ctrl_decode_stage_if (opcode in, control bundle out, flush,
//                multi-cycle busy and illegal/system flags)
// M-group ops are held for MUL_CYCLES / DIV_CYCLES before being offered to EX.
module ctrl_decode_stage
   import ctrl_decode_stage_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 3,
   parameter int unsigned DIV_CYCLES = 8,
   parameter bit          ENABLE_M   = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   ctrl_decode_stage_if.slave bus
);

   typedef enum logic [1:0] {StEmpty, StWait, StReady} state_e;

   localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_load;
   ctrl_bundle_t     ctrl_q, ctrl_d;
   logic             illegal_q, illegal_d;
   logic             sys_q, sys_d;

   ctrl_bundle_t     dec_ctrl;
   logic             dec_mul, dec_div, dec_illegal, dec_sys;
   logic             handoff, in_ready, load;

   ctrl_decode_comb #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .opcode  (bus.opcode_in),
      .ctrl    (dec_ctrl),
      .is_mul  (dec_mul),
      .is_div  (dec_div),
      .illegal (dec_illegal),
      .sys     (dec_sys)
   );

   always_comb begin
      handoff   = (state_q == StReady) && bus.out_ready;
      in_ready  = (state_q == StEmpty) || handoff;
      load      = bus.in_valid && in_ready && !bus.flush;
      cnt_load  = dec_mul ? MulLoad : (dec_div ? DivLoad : '0);

      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      sys_d     = sys_q;

      if (bus.flush) begin
         // Bundle register deliberately untouched; out_valid=0 makes it don't-care.
         state_d   = StEmpty;
         cnt_d     = '0;
         illegal_d = 1'b0;
         sys_d     = 1'b0;
      end else if (load) begin
         ctrl_d    = dec_ctrl;
         illegal_d = dec_illegal;
         sys_d     = dec_sys;
         cnt_d     = cnt_load;
         state_d   = (cnt_load == '0) ? StReady : StWait;
      end else begin
         unique case (state_q)
            StWait: begin
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               if (cnt_d == '0) state_d = StReady;
            end
            StReady: if (bus.out_ready) state_d = StEmpty;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StEmpty;
         cnt_q     <= '0;
         ctrl_q    <= CTRL_NOP;
         illegal_q <= 1'b0;
         sys_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         sys_q     <= sys_d;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = (state_q == StReady);
   assign bus.mc_busy       = (state_q == StWait);
   assign bus.ctrl_out      = ctrl_q;
   assign bus.illegal_instr = illegal_q;
   assign bus.sys_trap      = sys_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: three instances (default, single-cycle M, M disabled) share one
// stimulus stream; a cycle-count reference model predicts every output.
module tb_ctrl_decode_stage;
   import ctrl_decode_stage_pkg::*;

   localparam int NDUT = 3;
   localparam int unsigned MULC [NDUT] = '{3, 1, 3};
   localparam int unsigned DIVC [NDUT] = '{8, 1, 8};
   localparam bit          EN_M [NDUT] = '{1'b1, 1'b1, 1'b0};

   typedef struct packed {
      logic         valid;
      logic         busy;
      logic         rdy;
      logic         ill;
      logic         sys;
      ctrl_bundle_t ctrl;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n;
   opcode_out_t d_op;
   logic        d_valid, d_flush, d_ordy;
   obs_t        obs [NDUT];

   always #5 clk = ~clk;

   ctrl_decode_stage_if bus0 ();
   ctrl_decode_stage_if bus1 ();
   ctrl_decode_stage_if bus2 ();

   assign bus0.opcode_in = d_op;  assign bus0.in_valid = d_valid;
   assign bus0.flush = d_flush;   assign bus0.out_ready = d_ordy;
   assign bus1.opcode_in = d_op;  assign bus1.in_valid = d_valid;
   assign bus1.flush = d_flush;   assign bus1.out_ready = d_ordy;
   assign bus2.opcode_in = d_op;  assign bus2.in_valid = d_valid;
   assign bus2.flush = d_flush;   assign bus2.out_ready = d_ordy;

   assign obs[0] = {bus0.out_valid, bus0.mc_busy, bus0.in_ready, bus0.illegal_instr,
                    bus0.sys_trap, bus0.ctrl_out};
   assign obs[1] = {bus1.out_valid, bus1.mc_busy, bus1.in_ready, bus1.illegal_instr,
                    bus1.sys_trap, bus1.ctrl_out};
   assign obs[2] = {bus2.out_valid, bus2.mc_busy, bus2.in_ready, bus2.illegal_instr,
                    bus2.sys_trap, bus2.ctrl_out};

   ctrl_decode_stage #(.MUL_CYCLES(3), .DIV_CYCLES(8), .ENABLE_M(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   ctrl_decode_stage #(.MUL_CYCLES(1), .DIV_CYCLES(1), .ENABLE_M(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));
   ctrl_decode_stage #(.MUL_CYCLES(3), .DIV_CYCLES(8), .ENABLE_M(1'b0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2));

   // Reference model: held instruction plus the absolute cycle at which it becomes issuable.
   bit           m_held     [NDUT];
   longint       m_valid_at [NDUT];
   ctrl_bundle_t m_ctrl     [NDUT];
   bit           m_ill      [NDUT];
   bit           m_sys      [NDUT];
   longint       cyc;
   int           n_pass, n_total, n_fail;

   alu_op_t itab [9] = '{ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
                         ALU_SLL, ALU_SRL, ALU_SRA};

   task automatic chk(input string tag, input int d, input logic [63:0] o, input logic [63:0] e);
      n_total++;
      assert (o === e) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, o, e);
      end
   endtask

   // Decode rules computed from opcode position within its instruction group.
   function automatic void ref_decode(input opcode_out_t op, input int d, output ctrl_bundle_t b,
                                      output bit ill, output bit sys, output int lat);
      int k;
      k   = int'(op);
      b   = CTRL_NOP;
      ill = 1'b0;
      sys = 1'b0;
      lat = 1;
      if (k <= int'(AND)) begin
         b.reg_do_write = 1'b1;
         b.alu_op       = alu_op_t'(k);
      end else if (k <= int'(SRAI)) begin
         b.reg_do_write = 1'b1;
         b.alu_src2     = SRC2_IMM;
         b.alu_op       = itab[k - int'(ADDI)];
      end else if (k <= int'(LHU)) begin
         b.reg_do_write = 1'b1;
         b.mem_do_read  = 1'b1;
         b.alu_src2     = SRC2_IMM;
         b.wr_src       = WRSRC_MEMREAD;
         b.mem_op       = mem_op_t'(k - int'(LB));
      end else if (k <= int'(SW)) begin
         b.mem_do_write = 1'b1;
         b.alu_src2     = SRC2_IMM;
         b.mem_op       = mem_op_t'(k - int'(LB));
      end else if (k <= int'(BGEU)) begin
         b.do_branch = 1'b1;
         b.alu_src1  = SRC1_PC;
         b.alu_src2  = SRC2_IMM;
         b.comp_op   = comp_op_t'(k - int'(BEQ));
      end else if (k <= int'(JALR)) begin
         b.do_jump      = 1'b1;
         b.reg_do_write = 1'b1;
         b.wr_src       = WRSRC_PC4;
         b.alu_src1     = (op == JAL) ? SRC1_PC : SRC1_REG1;
         b.alu_src2     = SRC2_IMM;
      end else if (k <= int'(AUIPC)) begin
         b.reg_do_write = 1'b1;
         b.alu_src1     = (op == LUI) ? SRC1_ZERO : SRC1_PC;
         b.alu_src2     = SRC2_IMM;
      end else if (k <= int'(EBREAK)) begin
         sys = 1'b1;
      end else if (k <= int'(REMU) && EN_M[d]) begin
         b.reg_do_write = 1'b1;
         b.alu_op       = alu_op_t'(int'(ALU_MUL) + k - int'(MUL));
         lat            = (k <= int'(MULHU)) ? int'(MULC[d]) : int'(DIVC[d]);
      end else begin
         ill = 1'b1;
      end
   endfunction

   task automatic model_reset();
      for (int d = 0; d < NDUT; d++) begin
         m_held[d] = 1'b0;
         m_ctrl[d] = CTRL_NOP;
         m_ill[d]  = 1'b0;
         m_sys[d]  = 1'b0;
      end
   endtask

   task automatic check_reset_values();
      for (int d = 0; d < NDUT; d++) begin
         chk("rst_out_valid", d, 64'(obs[d].valid), 64'(0));
         chk("rst_mc_busy", d, 64'(obs[d].busy), 64'(0));
         chk("rst_in_ready", d, 64'(obs[d].rdy), 64'(1));
         chk("rst_illegal", d, 64'(obs[d].ill), 64'(0));
         chk("rst_sys_trap", d, 64'(obs[d].sys), 64'(0));
         chk("rst_ctrl_out", d, 64'(obs[d].ctrl), 64'(CTRL_NOP));
      end
   endtask

   // One clock cycle: drive inputs, check all outputs against the model, advance the model.
   task automatic step(input bit v, input opcode_out_t op, input bit fl, input bit ordy);
      bit           ov, ir, nill, nsys;
      ctrl_bundle_t nb;
      int           lat;
      d_valid = v;
      d_op    = op;
      d_flush = fl;
      d_ordy  = ordy;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         ov = m_held[d] && (cyc >= m_valid_at[d]);
         ir = !m_held[d] || (ov && ordy);
         chk("out_valid", d, 64'(obs[d].valid), 64'(ov));
         chk("mc_busy", d, 64'(obs[d].busy), 64'(m_held[d] && !ov));
         chk("in_ready", d, 64'(obs[d].rdy), 64'(ir));
         chk("ctrl_out", d, 64'(obs[d].ctrl), 64'(m_ctrl[d]));
         if (m_held[d]) begin
            chk("illegal_instr", d, 64'(obs[d].ill), 64'(m_ill[d]));
            chk("sys_trap", d, 64'(obs[d].sys), 64'(m_sys[d]));
         end
         if (fl) begin
            m_held[d] = 1'b0;
            m_ill[d]  = 1'b0;
            m_sys[d]  = 1'b0;
         end else if (v && ir) begin
            ref_decode(op, d, nb, nill, nsys, lat);
            m_held[d]     = 1'b1;
            m_valid_at[d] = cyc + longint'(lat);
            m_ctrl[d]     = nb;
            m_ill[d]      = nill;
            m_sys[d]      = nsys;
         end else if (ov && ordy) begin
            m_held[d] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      opcode_out_t rop;
      n_pass  = 0;
      n_total = 0;
      n_fail  = 0;
      cyc     = 0;
      d_valid = 1'b0;
      d_op    = ADD;
      d_flush = 1'b0;
      d_ordy  = 1'b1;
      rst_n   = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD: loads now, valid next cycle.
      step(1'b1, ADD, 1'b0, 1'b1);
      chk("add_valid", 0, 64'(obs[0].valid), 64'(1));
      chk("add_alu_op", 0, 64'(obs[0].ctrl.alu_op), 64'(ALU_ADD));
      chk("add_reg_wr", 0, 64'(obs[0].ctrl.reg_do_write), 64'(1));
      step(1'b0, ADD, 1'b0, 1'b1);

      // DIV then ADD accepted in the cycle the DIV becomes valid.
      step(1'b1, DIV, 1'b0, 1'b1);
      repeat (7) step(1'b1, ADD, 1'b0, 1'b1);
      chk("div_valid", 0, 64'(obs[0].valid), 64'(1));
      step(1'b1, ADD, 1'b0, 1'b1);
      step(1'b0, ADD, 1'b0, 1'b1);

      // MUL: illegal NOP on the M-disabled instance, multi-cycle elsewhere.
      step(1'b1, MUL, 1'b0, 1'b1);
      chk("mul_dis_illegal", 2, 64'(obs[2].ill), 64'(1));
      repeat (3) step(1'b0, ADD, 1'b0, 1'b1);

      // LW stalled by EX, SW queued and taken when out_ready rises.
      step(1'b1, LW, 1'b0, 1'b1);
      repeat (3) step(1'b1, SW, 1'b0, 1'b0);
      chk("lw_mem_op", 0, 64'(obs[0].ctrl.mem_op), 64'(MEM_LW));
      chk("lw_wr_src", 0, 64'(obs[0].ctrl.wr_src), 64'(WRSRC_MEMREAD));
      step(1'b1, SW, 1'b0, 1'b1);
      step(1'b0, ADD, 1'b0, 1'b1);

      // MUL flushed with cnt=1; BEQ in the flush cycle is dropped.
      step(1'b1, MUL, 1'b0, 1'b1);
      step(1'b0, ADD, 1'b0, 1'b1);
      step(1'b1, BEQ, 1'b1, 1'b1);
      chk("flush_valid", 0, 64'(obs[0].valid), 64'(0));
      step(1'b0, ADD, 1'b0, 1'b1);

      // System and illegal opcodes.
      step(1'b1, ECALL, 1'b0, 1'b1);
      step(1'b1, ILLEGAL, 1'b0, 1'b1);
      step(1'b1, JAL, 1'b0, 1'b1);
      step(1'b0, ADD, 1'b0, 1'b1);

      // Asynchronous reset mid-DIV, between clock edges.
      step(1'b1, DIV, 1'b0, 1'b1);
      repeat (3) step(1'b0, ADD, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0)
            rop = opcode_out_t'(6'($urandom_range(int'(MUL), int'(REMU))));
         else
            rop = opcode_out_t'(6'($urandom_range(0, 63)));
         step($urandom_range(0, 3) != 0, rop, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered instruction-decode control stage for the 5-stage core, sitting between the ID decoder output and the ID/EX boundary. It decodes `opcode_out_t` into a full control bundle and holds it in a valid/ready pipeline register. It adds M-extension decode with a parametrised multi-cycle hold, illegal/system-instruction flagging, and flush. Downstream EX logic consumes `ctrl_out` only when `out_valid && out_ready`.

## Interface
- `MUL_CYCLES`, default 3: EX occupancy of MUL/MULH/MULHSU/MULHU, range 1–16.
- `DIV_CYCLES`, default 8: EX occupancy of DIV/DIVU/REM/REMU, range 1–32.
- `ENABLE_M`, default 1: 0 makes every M opcode illegal.
- `clk` in 1: the block's single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset; assertion clears state immediately, independent of `clk`.
- `opcode_in` in `opcode_out_t`: decoded opcode from the ID stage.
- `in_valid` in 1: `opcode_in` is valid.
- `in_ready` out 1: the stage can accept `opcode_in` this cycle.
- `flush` in 1: kill the held instruction (branch or jump redirect).
- `out_ready` in 1: EX can accept the held bundle.
- `out_valid` out 1: `ctrl_out` is valid and issuable.
- `ctrl_out` out `ctrl_bundle_t`: registered control bundle.
- `mc_busy` out 1: a multi-cycle op is counting down.
- `illegal_instr` out 1: registered flag; the held instruction is undefined, or is an M op with `ENABLE_M=0`.
- `sys_trap` out 1: registered flag; the held instruction is ECALL or EBREAK.

## Operation
- **Decode.** Combinational, same mapping as the existing RV32I decode:
  - R-type, I-type, load, store, branch, JAL/JALR, LUI and AUIPC produce the same control fields as today.
  - The M group sets `reg_do_write=1`, `alu_src1=SRC1_REG1`, `alu_src2=SRC2_REG2`, `wr_src=WRSRC_ALURES`.
  - M group ALU ops: ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
- **Illegal and system instructions.** Any illegal opcode, or any M opcode with `ENABLE_M=0`:
  - The bundle is the all-default NOP bundle (every write, read, branch and jump enable is 0).
  - `illegal_instr=1` is set.
  - ECALL and EBREAK also give the NOP bundle, with `sys_trap=1`.
- **Load.** `load = in_valid && in_ready && !flush`. On `load` the stage captures the bundle, both flags and the cycle counter.
- **Cycle counter (`cnt`).**
  - Loads with `MUL_CYCLES-1` for the MUL group, `DIV_CYCLES-1` for the DIV/REM group, and 0 otherwise.
  - Decrements by 1 each cycle while it is nonzero.
  - Saturates at 0 and never wraps.
- **States.**
  - EMPTY: `out_valid=0`.
  - WAIT: instruction held, `cnt>0`, `mc_busy=1`, `out_valid=0`.
  - READY: instruction held, `cnt==0`, `out_valid=1`.
- **Transitions.**
  - EMPTY goes to READY on `load` with `cnt` load value 0, and to WAIT on `load` with load value >0.
  - WAIT goes to READY when `cnt` reaches 0.
  - READY with `out_ready`: goes to READY or WAIT on a simultaneous `load`; otherwise to EMPTY.
  - READY without `out_ready`: holds, and `ctrl_out` stays stable.
- **`in_ready`** = `!held || (out_valid && out_ready)`, which is 0 in WAIT.
- **Flush** has priority over everything else:
  - The next state is EMPTY, `cnt` goes to 0, and both flags clear.
  - `in_valid` in the flush cycle is dropped.
  - The bundle register is left unchanged.
- While `out_valid=0`, EX must ignore `ctrl_out`. The bundle is not zeroed, except on reset.

## Timing
- **Latency.** `load` in cycle N gives `out_valid` in cycle N+1 for single-cycle ops, and in cycle N+MUL_CYCLES or N+DIV_CYCLES for multi-cycle ops.
- **Throughput.** One instruction per cycle when `out_ready` stays high and no multi-cycle op is held.
- **Registered outputs.** `ctrl_out`, `out_valid`, `illegal_instr`, `sys_trap` and `mc_busy` are all registered.
- **Combinational outputs.** `in_ready` is combinational from state and `out_ready`; there is no combinational path from `opcode_in`.
- **Reset values** (asynchronous, on `rst_n=0`):
  - `out_valid=0`, `mc_busy=0`, `illegal_instr=0`, `sys_trap=0`.
  - `cnt=0`, state EMPTY.
  - `ctrl_out` = NOP bundle.
- **Reset mid-operation:** state is lost immediately and the stage restarts in EMPTY after `rst_n` rises. `in_ready=1` in the first cycle after reset.
- **Boundary cases.**
  - `MUL_CYCLES=1` or `DIV_CYCLES=1` behaves exactly like a single-cycle op.
  - `flush` and `out_ready` in the same READY cycle: the flush wins, and EX must also squash that handoff.

## Structure
- **`opcodes` package:**
  - Adds the M-extension opcode enum entries (MUL…REMU) plus ILLEGAL.
- **`control_types` package:**
  - Adds ALU_MUL…ALU_REMU to `alu_op_t`.
  - Adds `ctrl_bundle_t`, a packed struct: `reg_do_write`, `mem_do_write`, `mem_do_read`, `do_branch`, `do_jump`, `comp_op_t`, `reg_wr_src_t`, `alu_src1_t`, `alu_src2_t`, `alu_op_t`, `mem_op_t`.
  - Adds `CTRL_NOP` as a localparam of type `ctrl_bundle_t`.
- **Sub-module `ctrl_decode_comb`:** purely combinational `opcode_out_t` → (`ctrl_bundle_t`, `is_mul`, `is_div`, `illegal`, `sys`). It takes `ENABLE_M` as a parameter.
- **Top level:** `ctrl_decode_stage` holds the state register, counter and handshake.

## Test plan
- Reset with `ENABLE_M=1`, then ADD with `out_ready=1`: ADD loads in cycle 1, and in cycle 2 `out_valid=1`, `alu_op=ALU_ADD`, `reg_do_write=1`.
- DIV with `DIV_CYCLES=8`: `mc_busy=1` and `in_ready=0` for cycles 2–8, then `out_valid=1` in cycle 9. A following ADD is accepted in cycle 9 and is valid in cycle 10.
- `ENABLE_M=0`, then MUL: `out_valid=1` with `illegal_instr=1` and a NOP bundle, and `mc_busy` is never asserted.
- LW held with `out_ready=0` for 3 cycles: `ctrl_out` stays stable (`mem_op=MEM_LW`, `wr_src=WRSRC_MEMREAD`) and `in_ready=0`. When `out_ready` rises, the queued SW is accepted in the same cycle.
- MUL in WAIT (`cnt=1`) plus `flush`: the next cycle has `out_valid=0`, `mc_busy=0`, `cnt=0`. A BEQ presented during the flush cycle is dropped.
- `rst_n` pulsed low asynchronously mid-DIV (between clock edges): all outputs reach reset values before the next edge, and the stage is EMPTY with `in_ready=1` after release.
